// File: rtl/uart_bram_cmd_ctrl.sv
// UART byte-frame sequencer owning the map BRAM port: W frames write, R frames read back, others NAK.
// WE two cycles after the final RX byte; replies wait on TXBUSY, RX bytes outside frame intake are dropped.
module uart_bram_cmd_ctrl #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 12,
   parameter int TIMEOUT = 5_000_000
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [7:0]        RXDATA,
   input  logic              RXDONE,
   output logic [7:0]        TXDATA,
   output logic              TXSTART,
   input  logic              TXBUSY,
   input  logic              TXDONE,
   output logic              WE,
   output logic [AWIDTH-1:0] ADDR,
   output logic [DWIDTH-1:0] DATAI,
   input  logic [DWIDTH-1:0] DATAO,
   output logic              BUSY
);

   localparam int NB = DWIDTH / 8;
   localparam int CW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_NB   = CW'(NB);
   localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] REPLY_ACK = 8'h06;
   localparam logic [7:0] REPLY_NAK = 8'h15;

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GET_DATA, WRITE, RD_ADDR, RD_LATCH, TX_LOAD, TX_WAIT
   } state_t;

   state_t state, state_nxt;
   logic we_nxt, txstart_nxt;
   logic [7:0] opcode;
   logic [7:0] addr_hi;
   logic addr_cnt;
   logic [CW-1:0] byte_cnt;
   logic [CW-1:0] tx_cnt;
   logic [DWIDTH-1:0] tx_shift;
   logic [TW-1:0] tmo_cnt;
   logic tmo_hit;

   assign BUSY = (state != IDLE);
   assign tmo_hit = ((state == GET_ADDR) || (state == GET_DATA)) && !RXDONE && (tmo_cnt == TMO_LAST);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      we_nxt      = 1'b0;
      txstart_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (RXDONE) begin
               if (RXDATA == OP_WRITE || RXDATA == OP_READ) state_nxt = GET_ADDR;
               else                                          state_nxt = TX_LOAD;
            end
         end
         GET_ADDR: begin
            if (tmo_hit)
               state_nxt = IDLE;
            else if (RXDONE && addr_cnt)
               state_nxt = (opcode == OP_WRITE) ? GET_DATA : RD_ADDR;
         end
         GET_DATA: begin
            if (tmo_hit)
               state_nxt = IDLE;
            else if (RXDONE && byte_cnt == CNT_LAST)
               state_nxt = WRITE;
         end
         WRITE: begin
            we_nxt    = 1'b1;
            state_nxt = TX_LOAD;
         end
         RD_ADDR:  state_nxt = RD_LATCH;
         RD_LATCH: state_nxt = TX_LOAD;
         TX_LOAD: begin
            if (!TXBUSY) begin
               txstart_nxt = 1'b1;
               state_nxt   = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (TXDONE) state_nxt = (tx_cnt == CNT_ONE) ? IDLE : TX_LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath; WE/TXSTART are registered so they rise one cycle after the deciding state.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         opcode   <= '0;
         addr_hi  <= '0;
         addr_cnt <= 1'b0;
         byte_cnt <= '0;
         tx_cnt   <= '0;
         tx_shift <= '0;
         tmo_cnt  <= '0;
         ADDR     <= '0;
         DATAI    <= '0;
         TXDATA   <= '0;
         WE       <= 1'b0;
         TXSTART  <= 1'b0;
      end else begin
         WE      <= we_nxt;
         TXSTART <= txstart_nxt;
         case (state)
            IDLE: begin
               if (RXDONE) begin
                  opcode   <= RXDATA;
                  addr_cnt <= 1'b0;
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  if (RXDATA != OP_WRITE && RXDATA != OP_READ) begin
                     tx_shift <= {REPLY_NAK, {(DWIDTH-8){1'b0}}};
                     tx_cnt   <= CNT_ONE;
                  end
               end
            end
            GET_ADDR: begin
               if (RXDONE) begin
                  tmo_cnt  <= '0;
                  addr_cnt <= 1'b1;
                  addr_hi  <= RXDATA;
                  if (addr_cnt) ADDR <= AWIDTH'({addr_hi, RXDATA});
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GET_DATA: begin
               if (RXDONE) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= byte_cnt + 1'b1;
                  DATAI    <= DWIDTH'({DATAI, RXDATA});
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WRITE: begin
               tx_shift <= {REPLY_ACK, {(DWIDTH-8){1'b0}}};
               tx_cnt   <= CNT_ONE;
            end
            RD_LATCH: begin
               tx_shift <= DATAO;
               tx_cnt   <= CNT_NB;
            end
            TX_LOAD: begin
               if (!TXBUSY) TXDATA <= tx_shift[DWIDTH-1 -: 8];
            end
            TX_WAIT: begin
               if (TXDONE) begin
                  tx_shift <= tx_shift << 8;
                  tx_cnt   <= tx_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
